// File: rtl/bnn_xnor_sequencer_pkg.sv
// rtl/bnn_xnor_sequencer_pkg.sv - shared ALU op codes, FSM state codes and bit-match helper
package bnn_xnor_sequencer_pkg;

  localparam int ACC_W_FIXED = 12;

  localparam logic alu_op_add1 = 1'b0;
  localparam logic alu_op_sub1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // XNOR of two ±1 bits: 1 when the product is +1
  function automatic logic bit_match(input logic act, input logic wgt);
    return ~(act ^ wgt);
  endfunction

endpackage

// File: rtl/bnn_vec_shreg.sv
// rtl/bnn_vec_shreg.sv - activation/weight shift registers with per-bit match and last-step flag
module bnn_vec_shreg
  import bnn_xnor_sequencer_pkg::*;
#(
  parameter int VEC_LEN = 64,
  parameter int CNT_W   = $clog2(VEC_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [VEC_LEN-1:0] act_vec,
  input  logic [VEC_LEN-1:0] wgt_vec,
  output logic               match,
  output logic               last
);

  logic [VEC_LEN-1:0] act_sr;
  logic [VEC_LEN-1:0] wgt_sr;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_sr <= '0;
      wgt_sr <= '0;
      cnt    <= '0;
    end else if (load) begin
      act_sr <= act_vec;
      wgt_sr <= wgt_vec;
      cnt    <= '0;
    end else if (shift) begin
      act_sr <= act_sr >> 1;
      wgt_sr <= wgt_sr >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign match = bit_match(act_sr[0], wgt_sr[0]);
  assign last  = (cnt == CNT_W'(VEC_LEN - 1));

endmodule

// File: rtl/bnn_xnor_sequencer.sv
// rtl/bnn_xnor_sequencer.sv - bit-serial XNOR/popcount driver for the shared ±1 accumulate ALU
// Optional sign-activation output port out_act enabled by BNN_SIGN_ACT_EN.
module bnn_xnor_sequencer
  import bnn_xnor_sequencer_pkg::*;
#(
  parameter int VEC_LEN = 64,
  parameter int ACC_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VEC_LEN-1:0] act_vec,
  input  logic [VEC_LEN-1:0] wgt_vec,
  input  logic [ACC_W-1:0]   bias,
  output logic               alu_op,
  output logic               alu_in_a_lsb,
  output logic [ACC_W-1:0]   alu_in_b,
  input  logic [ACC_W-1:0]   alu_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
`ifdef BNN_SIGN_ACT_EN
  output logic               out_act,
`endif
  output logic               busy
);

  if (VEC_LEN < 1 || VEC_LEN > 1024) begin : g_bad_vec_len
    $error("bnn_xnor_sequencer: VEC_LEN must be in 1..1024");
  end
  if (ACC_W != ACC_W_FIXED) begin : g_bad_acc_w
    $error("bnn_xnor_sequencer: ACC_W must match the ALU width of 12");
  end

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic             load;
  logic             match;
  logic             last;

  bnn_vec_shreg #(
    .VEC_LEN (VEC_LEN)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (state == ST_RUN),
    .act_vec (act_vec),
    .wgt_vec (wgt_vec),
    .match   (match),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        acc <= bias;
      end else if (state == ST_RUN) begin
        acc <= alu_out;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    alu_op       = alu_op_add1;
    alu_in_a_lsb = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        alu_op       = match ? alu_op_add1 : alu_op_sub1;
        alu_in_a_lsb = 1'b1;
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // With idle ALU controls the ALU simply echoes acc, so acc can drive b in every state
  assign alu_in_b = acc;
  assign out_acc  = acc;

`ifdef BNN_SIGN_ACT_EN
  assign out_act = ~acc[ACC_W-1];
`endif

endmodule

// File: tb/tb_bnn_xnor_sequencer.sv
// tb/tb_bnn_xnor_sequencer.sv - self-checking bench for bnn_xnor_sequencer (VEC_LEN=8)
module tb_bnn_xnor_sequencer;
  import bnn_xnor_sequencer_pkg::*;

  localparam int VL = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VL-1:0] act_vec;
  logic [VL-1:0] wgt_vec;
  logic [AW-1:0] bias;
  logic          alu_op;
  logic          alu_in_a_lsb;
  logic [AW-1:0] alu_in_b;
  logic [AW-1:0] alu_out;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic          busy;
`ifdef BNN_SIGN_ACT_EN
  logic          out_act;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bnn_xnor_sequencer #(.VEC_LEN(VL), .ACC_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .act_vec      (act_vec),
    .wgt_vec      (wgt_vec),
    .bias         (bias),
    .alu_op       (alu_op),
    .alu_in_a_lsb (alu_in_a_lsb),
    .alu_in_b     (alu_in_b),
    .alu_out      (alu_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
`ifdef BNN_SIGN_ACT_EN
    .out_act      (out_act),
`endif
    .busy         (busy)
  );

  // Behavioural ±1 accumulate ALU
  assign alu_out = (alu_op == alu_op_add1) ? alu_in_b + {{(AW-1){1'b0}}, alu_in_a_lsb}
                                           : alu_in_b - {{(AW-1){1'b0}}, alu_in_a_lsb};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] ref_partial(input logic [VL-1:0] a, input logic [VL-1:0] w,
                                                input logic [AW-1:0] b, input int nbits);
    int s;
    s = $signed(b);
    for (int i = 0; i < nbits; i++) s += (a[i] == w[i]) ? 1 : -1;
    return s[AW-1:0];
  endfunction

  task automatic run_vec(input string name, input logic [VL-1:0] a, input logic [VL-1:0] w,
                         input logic [AW-1:0] b, input int hold, input bit poke, output int t_acc);
    logic [AW-1:0] exp_sum;
    logic          exp_op;
    logic [AW-1:0] exp_b;
    exp_sum = ref_partial(a, w, b, VL);
    act_vec = a;
    wgt_vec = w;
    bias = b;
    in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    step();
    t_acc = cyc;
    in_valid = 1'b0;
    act_vec = VL'($urandom);
    wgt_vec = VL'($urandom);
    bias = AW'($urandom);
    for (int k = 0; k < VL; k++) begin
      exp_op = (a[k] == w[k]) ? alu_op_add1 : alu_op_sub1;
      exp_b  = ref_partial(a, w, b, k);
      n_cmp++;
      if (alu_op !== exp_op || alu_in_a_lsb !== 1'b1 || alu_in_b !== exp_b ||
          out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s run step %0d: op=%b lsb=%b b=%h ov=%b ir=%b busy=%b want op=%b lsb=1 b=%h ov=0 ir=0 busy=1",
                 name, k, alu_op, alu_in_a_lsb, alu_in_b, out_valid, in_ready, busy, exp_op, exp_b);
      end
      step();
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== exp_sum || alu_op !== alu_op_add1 || alu_in_a_lsb !== 1'b0) begin
      n_bad++;
      $display("FAIL %s result: ov=%b acc=%h op=%b lsb=%b want ov=1 acc=%h op=%b lsb=0",
               name, out_valid, out_acc, alu_op, alu_in_a_lsb, exp_sum, alu_op_add1);
    end
`ifdef BNN_SIGN_ACT_EN
    n_cmp++;
    if (out_act !== ~exp_sum[AW-1]) begin
      n_bad++;
      $display("FAIL %s out_act: got %b want %b", name, out_act, ~exp_sum[AW-1]);
    end
`endif
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1;
        act_vec = VL'($urandom);
      end
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_acc !== exp_sum || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s hold %0d: ov=%b acc=%h ir=%b busy=%b want ov=1 acc=%h ir=0 busy=1",
                 name, h, out_valid, out_acc, in_ready, busy, exp_sum);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after handshake: ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== '0 || busy !== 1'b0 ||
        alu_op !== alu_op_add1 || alu_in_a_lsb !== 1'b0 || alu_in_b !== '0) begin
      n_bad++;
      $display("FAIL %s: ir=%b ov=%b acc=%h busy=%b op=%b lsb=%b b=%h want ir=1 ov=0 acc=0 busy=0 op=%b lsb=0 b=0",
               name, in_ready, out_valid, out_acc, busy, alu_op, alu_in_a_lsb, alu_in_b, alu_op_add1);
    end
`ifdef BNN_SIGN_ACT_EN
    n_cmp++;
    if (out_act !== 1'b1) begin
      n_bad++;
      $display("FAIL %s out_act: got %b want 1", name, out_act);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    act_vec = '0;
    wgt_vec = '0;
    bias = '0;
    step();
    step();
    rst = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_directed();
    int t;
    run_vec("all_match", 8'hFF, 8'hFF, 12'd0, 0, 1'b0, t);
    run_vec("all_mismatch", 8'hFF, 8'h00, 12'd0, 0, 1'b0, t);
    run_vec("mixed", 8'b0000_0101, 8'h00, 12'd0, 0, 1'b0, t);
  endtask

  task automatic test_backpressure();
    int t;
    run_vec("backpressure", 8'hF0, 8'hFF, 12'd5, 3, 1'b1, t);
  endtask

  task automatic test_abort();
    int t;
    act_vec = 8'h3C;
    wgt_vec = 8'hC3;
    bias = 12'd100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("abort");
    for (int i = 0; i < VL + 2; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort quiet %0d: ov=%b busy=%b want ov=0 busy=0", i, out_valid, busy);
      end
    end
    run_vec("after_abort", 8'hAA, 8'hAA, -12'sd3, 0, 1'b0, t);
    run_vec("neg_bias", 8'hAA, 8'hAA, -12'sd20, 0, 1'b0, t);
  endtask

  task automatic test_random();
    int t;
    logic [AW-1:0] b;
    for (int i = 0; i < 16; i++) begin
      b = AW'(int'($urandom_range(0, 4000)) - 2000);
      run_vec("random", VL'($urandom), VL'($urandom), b, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), t);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    run_vec("b2b_first", VL'($urandom), VL'($urandom), 12'd7, 0, 1'b0, t0);
    run_vec("b2b_second", VL'($urandom), VL'($urandom), -12'sd7, 0, 1'b0, t1);
    n_cmp++;
    if (t1 - t0 !== VL + 2) begin
      n_bad++;
      $display("FAIL back_to_back interval: got %0d want %0d", t1 - t0, VL + 2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
